// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to release a grant whose owner stays idle for IDLE_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state, state_nxt;
  logic [1:0]        owner, owner_nxt;
  logic [1:0]        ptr, ptr_nxt;
  logic [1:0]        owner_inc;
  logic [1:0]        pick, cand;
  logic              found;
  logic [N_REQ-1:0]  own_oh;
  logic              owner_valid, owner_last, xfer;

  always_comb begin
    own_oh  = '0;
    tx_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      own_oh[i] = (owner == 2'(i));
      if (owner == 2'(i)) tx_data = req_data[8*i +: 8];
    end
    if (state != LOCK) tx_data = '0;
  end

  assign owner_valid = |(own_oh & req_valid);
  assign owner_last  = |(own_oh & req_last);
  assign busy        = (state == LOCK);
  assign grant       = busy ? own_oh : '0;
  assign tx_valid    = busy && owner_valid;
  assign req_ready   = (busy && tx_ready) ? own_oh : '0;
  assign xfer        = tx_valid && tx_ready;
  assign owner_inc   = (owner == 2'(N_REQ - 1)) ? 2'd0 : owner + 2'd1;

  // First valid requester scanning upward from ptr with wrap.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 2'((32'(ptr) + k) % N_REQ);
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!found && cand == 2'(i) && req_valid[i]) begin
          found = 1'b1;
          pick  = cand;
        end
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [7:0] idle_cnt;
  logic       idle_expired;

  assign idle_expired = !owner_valid && (idle_cnt == 8'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state == LOCK && state_nxt == LOCK && !owner_valid) begin
      idle_cnt <= idle_cnt + 8'd1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |8'(IDLE_TIMEOUT);
`endif

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = LOCK;
          owner_nxt = pick;
        end
      end
      LOCK: begin
        if (xfer && owner_last) begin
          state_nxt = IDLE;
          ptr_nxt   = owner_inc;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (idle_expired) begin
          state_nxt = IDLE;
          ptr_nxt   = owner_inc;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule
